vip_cti_mode_switch_ctrl: RTL and testbench
===========================================

# vip_cti_mode_switch_ctrl

Sequencer for the clocked-video frame counter: holds a small table of video modes (h/v totals and counter reset positions), accepts mode-change requests over a valid/ready handshake, and applies a new mode only at a frame boundary by pulsing the counter's synchronous clear with the new values, then holding the counter for a settle period. It sits between the control-register slave and the frame counter, and owns that counter's `sclr`, `enable` and size/reset inputs.

## Interface
- `NUM_MODES`, 4: number of mode-table entries.
- `LOG2_NUM_MODES`, 2: width of mode indices.
- `SETTLE_CYCLES`, 16: cycles the counter is held after a load; minimum 1.
- `TOTALS_MINUS_ONE`, 0: matches the counter; if 0, end-of-frame compare uses `v_total-1`, else `v_total`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_wr` in 1: mode-table write strobe.
- `cfg_addr` in LOG2_NUM_MODES: entry written.
- `cfg_h_total`, `cfg_h_reset` in 14: horizontal total and reset value.
- `cfg_v_total`, `cfg_v_reset` in 13: vertical total and reset value.
- `mode_req_valid` in 1: mode-change request.
- `mode_req_id` in LOG2_NUM_MODES: requested entry.
- `mode_req_ready` out 1: request accepted when valid and ready are both high.
- `run` in 1: system run gate.
- `fc_new_line` in 1: counter end-of-line.
- `fc_v_count` in 13: counter line number.
- `fc_sclr` out 1: counter synchronous clear.
- `fc_enable` out 1: counter enable.
- `fc_h_total`, `fc_h_reset` out 14: counter horizontal inputs.
- `fc_v_total`, `fc_v_reset` out 13: counter vertical inputs.
- `active_mode` out LOG2_NUM_MODES: last loaded entry.
- `busy` out 1: state not IDLE/RUN, or a request is pending.
- `done` out 1: one-cycle pulse on entry to RUN.
- `req_err` out 1: one-cycle pulse when a request names an unwritten entry.

## Operation
- Each table entry has a valid bit, set by `cfg_wr` and cleared only by reset. Writes are accepted in any state.
- States:
  - IDLE: counter stopped.
  - LOAD: one cycle.
  - SETTLE: `SETTLE_CYCLES` cycles.
  - RUN: normal counting.
  - WAIT_EOF: request pending until end of frame.
- `mode_req_ready` = 1 in IDLE and RUN, 0 otherwise.
- Acceptance of a request for an unwritten entry: `req_err` pulses, no state change.
- Valid acceptance in IDLE -> LOAD. Valid acceptance in RUN -> WAIT_EOF, with the id captured in `pending_id`.
- EOF = `fc_enable & fc_new_line & (fc_v_count >= v_total_int)`, where `v_total_int` is derived from the currently applied `fc_v_total`. WAIT_EOF exits to LOAD on EOF.
- LOAD:
  - `fc_sclr`=1 and `fc_enable`=0.
  - `fc_*` size/reset outputs are registered from the table entry on entry to LOAD, so they are valid during the `sclr` cycle.
  - `active_mode` is updated on entry to LOAD.
- SETTLE: `fc_enable`=0; down-counter from `SETTLE_CYCLES-1`; at 0 -> RUN with a `done` pulse.
- RUN and WAIT_EOF: `fc_enable` = `run`. With `run` low the counter freezes and WAIT_EOF waits indefinitely.
- Table writes never alter `fc_*` outputs directly; they take effect only at the next LOAD.

## Timing
- Reset values:
  - All outputs 0 except `mode_req_ready`=1.
  - State IDLE, all valid bits 0, `pending_id` 0.
- Request accepted in IDLE at cycle t:
  - `fc_sclr` high at t+1 with the new values.
  - `fc_enable` low from t+1 through t+1+`SETTLE_CYCLES`.
  - RUN and `done` at t+2+`SETTLE_CYCLES`.
- In WAIT_EOF, EOF at cycle e -> `fc_sclr` at e+1.
- Boundary cases:
  - EOF in the same cycle as acceptance in RUN: ignored, because EOF is evaluated only in WAIT_EOF; the mode applies at the following frame end.
  - `cfg_wr` to the loading entry in the cycle of entry to LOAD: the old value is loaded; the new value persists in the table.
  - Request for the already-active mode: full LOAD/SETTLE sequence is still performed.
  - `rst_n` low mid-sequence: immediate return to reset values; table contents are lost.

## Structure
- Shared package holds:
  - state encoding.
  - mode-entry record: h_total 14, v_total 13, h_reset 14, v_reset 13, valid 1.
  - width constants 14/13.
- One sub-module, `vip_cti_mode_table`: register array with write port, combinational read and valid bits. The FSM, settle counter and EOF compare live in the top block.

## Test plan
- Write entry 1 (h_total 858, v_total 525, resets 0/0); request id 1 from IDLE -> `fc_sclr` one cycle at t+1 with 858/525; `done` at t+18; `active_mode`=1.
- Request id 2 while unwritten -> `req_err` pulse, state and outputs unchanged, `mode_req_ready` stays 1.
- In RUN with mode 1, request mode 0 (h_total 1650, v_total 750) mid-frame -> `fc_sclr` exactly one cycle after new_line at `fc_v_count`=524; no earlier change.
- Drop `run` during WAIT_EOF for 100 cycles -> `fc_enable` low; load occurs only after `run` returns and EOF is reached.
- Rewrite entry 1 to v_total 625 while it is active -> outputs stay 525 until the next request for id 1, which loads 625.
- Assert `rst_n` low during SETTLE -> all outputs at reset values; a subsequent request for an unwritten entry -> `req_err`.

Source files
------------

// File: rtl/vip_cti_mode_switch_ctrl_pkg.sv
// vip_cti_mode_switch_ctrl_pkg: shared widths, state encoding and mode-table record
package vip_cti_mode_switch_ctrl_pkg;
  localparam int H_W = 14;
  localparam int V_W = 13;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_WAIT_EOF
  } state_t;
  typedef struct packed {
    logic [H_W-1:0] h_total;
    logic [V_W-1:0] v_total;
    logic [H_W-1:0] h_reset;
    logic [V_W-1:0] v_reset;
    logic           valid;
  } mode_entry_t;
endpackage

// File: rtl/vip_cti_mode_table.sv
// vip_cti_mode_table: mode register array with one write port, combinational read and per-entry valid bits
module vip_cti_mode_table
  import vip_cti_mode_switch_ctrl_pkg::*;
#(
  parameter int NUM_MODES      = 4,
  parameter int LOG2_NUM_MODES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr,
  input  logic [LOG2_NUM_MODES-1:0] i_waddr,
  input  mode_entry_t               i_wdata,
  input  logic [LOG2_NUM_MODES-1:0] i_raddr,
  output mode_entry_t               o_rdata,
  output logic [NUM_MODES-1:0]      o_valid
);
  mode_entry_t r_tab [NUM_MODES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MODES; i++) r_tab[i] <= '0;
    end else if (i_wr) begin
      r_tab[i_waddr]       <= i_wdata;
      r_tab[i_waddr].valid <= 1'b1;
    end
  end
  assign o_rdata = r_tab[i_raddr];
  always_comb begin
    o_valid = '0;
    for (int i = 0; i < NUM_MODES; i++) o_valid[i] = r_tab[i].valid;
  end
endmodule

// File: rtl/vip_cti_mode_switch_ctrl.sv
// vip_cti_mode_switch_ctrl: accepts mode-change requests and applies them to the frame counter
// only at a frame boundary, via a one-cycle sclr followed by a settle hold.
module vip_cti_mode_switch_ctrl
  import vip_cti_mode_switch_ctrl_pkg::*;
#(
  parameter int NUM_MODES        = 4,
  parameter int LOG2_NUM_MODES   = 2,
  parameter int SETTLE_CYCLES    = 16,
  parameter int TOTALS_MINUS_ONE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wr,
  input  logic [LOG2_NUM_MODES-1:0] cfg_addr,
  input  logic [H_W-1:0]            cfg_h_total,
  input  logic [H_W-1:0]            cfg_h_reset,
  input  logic [V_W-1:0]            cfg_v_total,
  input  logic [V_W-1:0]            cfg_v_reset,
  input  logic                      mode_req_valid,
  input  logic [LOG2_NUM_MODES-1:0] mode_req_id,
  output logic                      mode_req_ready,
  input  logic                      run,
  input  logic                      fc_new_line,
  input  logic [V_W-1:0]            fc_v_count,
  output logic                      fc_sclr,
  output logic                      fc_enable,
  output logic [H_W-1:0]            fc_h_total,
  output logic [H_W-1:0]            fc_h_reset,
  output logic [V_W-1:0]            fc_v_total,
  output logic [V_W-1:0]            fc_v_reset,
  output logic [LOG2_NUM_MODES-1:0] active_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      req_err
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  state_t                    r_state, w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [LOG2_NUM_MODES-1:0] r_pending_id, r_active, w_load_id;
  logic [NUM_MODES-1:0]      w_valid;
  mode_entry_t               w_wr_entry, w_rd_entry;
  logic [V_W-1:0]            w_v_total_int;
  logic                      w_accept, w_req_hit, w_eof, w_settled;
  logic                      r_done, r_req_err;
  logic [H_W-1:0]            r_fc_h_total, r_fc_h_reset;
  logic [V_W-1:0]            r_fc_v_total, r_fc_v_reset;

  assign w_wr_entry = '{h_total: cfg_h_total, v_total: cfg_v_total,
                        h_reset: cfg_h_reset, v_reset: cfg_v_reset, valid: 1'b1};

  vip_cti_mode_table #(
    .NUM_MODES      (NUM_MODES),
    .LOG2_NUM_MODES (LOG2_NUM_MODES)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (cfg_wr),
    .i_waddr (cfg_addr),
    .i_wdata (w_wr_entry),
    .i_raddr (w_load_id),
    .o_rdata (w_rd_entry),
    .o_valid (w_valid)
  );

  assign mode_req_ready = r_state == ST_IDLE || r_state == ST_RUN;
  assign w_accept       = mode_req_valid && mode_req_ready;
  assign w_req_hit      = w_accept && w_valid[mode_req_id];
  // Frame-end compare always tracks the mode currently applied to the counter
  assign w_v_total_int  = TOTALS_MINUS_ONE != 0 ? r_fc_v_total : r_fc_v_total - V_W'(1);
  assign w_eof          = fc_enable && fc_new_line && fc_v_count >= w_v_total_int;
  assign w_settled      = r_cnt == '0;
  assign w_load_id      = r_state == ST_IDLE ? mode_req_id : r_pending_id;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_req_hit) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_SETTLE;
      ST_SETTLE:   if (w_settled) w_next = ST_RUN;
      ST_RUN:      if (w_req_hit) w_next = ST_WAIT_EOF;
      ST_WAIT_EOF: if (w_eof) w_next = ST_LOAD;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pending_id <= '0;
      r_active     <= '0;
      r_done       <= 1'b0;
      r_req_err    <= 1'b0;
      r_fc_h_total <= '0;
      r_fc_h_reset <= '0;
      r_fc_v_total <= '0;
      r_fc_v_reset <= '0;
    end else begin
      r_state   <= w_next;
      r_done    <= r_state == ST_SETTLE && w_settled;
      r_req_err <= w_accept && !w_valid[mode_req_id];
      if (r_state == ST_LOAD) r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      else if (r_state == ST_SETTLE) r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == ST_RUN && w_req_hit) r_pending_id <= mode_req_id;
      if (w_next == ST_LOAD) begin
        r_active     <= w_load_id;
        r_fc_h_total <= w_rd_entry.h_total;
        r_fc_h_reset <= w_rd_entry.h_reset;
        r_fc_v_total <= w_rd_entry.v_total;
        r_fc_v_reset <= w_rd_entry.v_reset;
      end
    end
  end

  assign fc_sclr     = r_state == ST_LOAD;
  assign fc_enable   = (r_state == ST_RUN || r_state == ST_WAIT_EOF) && run;
  assign busy        = !mode_req_ready;
  assign done        = r_done;
  assign req_err     = r_req_err;
  assign active_mode = r_active;
  assign fc_h_total  = r_fc_h_total;
  assign fc_h_reset  = r_fc_h_reset;
  assign fc_v_total  = r_fc_v_total;
  assign fc_v_reset  = r_fc_v_reset;
endmodule

// File: tb/tb_vip_cti_mode_switch_ctrl.sv
// tb_vip_cti_mode_switch_ctrl: directed + randomized bench against a transaction-level mode-switch model
module tb_vip_cti_mode_switch_ctrl;
  localparam int S = 16;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [13:0] cfg_h_total = '0, cfg_h_reset = '0;
  logic [12:0] cfg_v_total = '0, cfg_v_reset = '0;
  logic        mode_req_valid = 1'b0;
  logic [1:0]  mode_req_id = '0;
  logic        mode_req_ready;
  logic        run = 1'b0, fc_new_line = 1'b0;
  logic [12:0] fc_v_count = '0;
  logic        fc_sclr, fc_enable, busy, done, req_err;
  logic [13:0] fc_h_total, fc_h_reset;
  logic [12:0] fc_v_total, fc_v_reset;
  logic [1:0]  active_mode;

  int n_checks = 0, n_errors = 0;
  int m_ht[4], m_vt[4], m_hr[4], m_vr[4];
  bit m_ok[4];
  int a_ht = 0, a_vt = 0, a_hr = 0, a_vr = 0, a_id = 0;

  always #5 clk = ~clk;

  vip_cti_mode_switch_ctrl #(
    .NUM_MODES(4), .LOG2_NUM_MODES(2), .SETTLE_CYCLES(S), .TOTALS_MINUS_ONE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_h_total(cfg_h_total), .cfg_h_reset(cfg_h_reset),
    .cfg_v_total(cfg_v_total), .cfg_v_reset(cfg_v_reset),
    .mode_req_valid(mode_req_valid), .mode_req_id(mode_req_id), .mode_req_ready(mode_req_ready),
    .run(run), .fc_new_line(fc_new_line), .fc_v_count(fc_v_count),
    .fc_sclr(fc_sclr), .fc_enable(fc_enable),
    .fc_h_total(fc_h_total), .fc_h_reset(fc_h_reset),
    .fc_v_total(fc_v_total), .fc_v_reset(fc_v_reset),
    .active_mode(active_mode), .busy(busy), .done(done), .req_err(req_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_applied(input string t);
    chk({t, "_h_total"}, fc_h_total, a_ht);
    chk({t, "_v_total"}, fc_v_total, a_vt);
    chk({t, "_h_reset"}, fc_h_reset, a_hr);
    chk({t, "_v_reset"}, fc_v_reset, a_vr);
    chk({t, "_active"}, active_mode, a_id);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_sclr"}, fc_sclr, 0);
    chk({t, "_enable"}, fc_enable, 0);
    chk({t, "_ready"}, mode_req_ready, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_req_err"}, req_err, 0);
    chk_applied(t);
  endtask

  task automatic snap(input int id);
    a_ht = m_ht[id]; a_vt = m_vt[id]; a_hr = m_hr[id]; a_vr = m_vr[id]; a_id = id;
  endtask

  task automatic wr(input int id, input int ht, input int vt, input int hr, input int vr);
    cfg_wr = 1'b1; cfg_addr = 2'(id);
    cfg_h_total = 14'(ht); cfg_v_total = 13'(vt); cfg_h_reset = 14'(hr); cfg_v_reset = 13'(vr);
    step();
    cfg_wr = 1'b0;
    m_ht[id] = ht; m_vt[id] = vt; m_hr[id] = hr; m_vr[id] = vr; m_ok[id] = 1'b1;
    chk_applied("wr_no_effect");
  endtask

  // Entered in the cycle the counter clear is expected; follows the load through to RUN.
  task automatic settle_seq(input string t);
    chk({t, "_sclr"}, fc_sclr, 1);
    chk({t, "_enable_load"}, fc_enable, 0);
    chk({t, "_ready_load"}, mode_req_ready, 0);
    chk_applied(t);
    for (int k = 0; k < S; k++) begin
      step();
      chk({t, "_sclr_settle"}, fc_sclr, 0);
      chk({t, "_enable_settle"}, fc_enable, 0);
      chk({t, "_done_early"}, done, 0);
      chk({t, "_busy_settle"}, busy, 1);
    end
    step();
    chk({t, "_done"}, done, 1);
    chk({t, "_ready_run"}, mode_req_ready, 1);
    chk({t, "_enable_run"}, fc_enable, run);
    step();
    chk({t, "_done_pulse"}, done, 0);
  endtask

  task automatic req_idle(input int id);
    chk("idle_ready", mode_req_ready, 1);
    mode_req_valid = 1'b1; mode_req_id = 2'(id);
    snap(id);
    step();
    mode_req_valid = 1'b0; cfg_wr = 1'b0;
    settle_seq("idle_load");
  endtask

  task automatic req_err_seq(input int id);
    chk("err_ready_before", mode_req_ready, 1);
    mode_req_valid = 1'b1; mode_req_id = 2'(id);
    step();
    mode_req_valid = 1'b0;
    chk("err_pulse", req_err, 1);
    chk("err_ready", mode_req_ready, 1);
    chk("err_sclr", fc_sclr, 0);
    chk("err_busy", busy, 0);
    chk_applied("err_unchanged");
    step();
    chk("err_pulse_end", req_err, 0);
  endtask

  // Request from RUN; an end-of-frame line coincides with acceptance and must be ignored.
  task automatic req_run(input int id, input int lines, input int gap);
    int thr;
    thr = a_vt - 1;
    chk("run_ready", mode_req_ready, 1);
    mode_req_valid = 1'b1; mode_req_id = 2'(id);
    fc_new_line = 1'b1; fc_v_count = 13'(thr);
    step();
    mode_req_valid = 1'b0; fc_new_line = 1'b0;
    chk("wait_sclr_same_cycle_eof", fc_sclr, 0);
    chk("wait_ready", mode_req_ready, 0);
    chk("wait_busy", busy, 1);
    for (int l = 0; l < lines; l++) begin
      fc_new_line = 1'b1; fc_v_count = 13'($urandom_range(0, thr - 1));
      step();
      chk("wait_midframe_sclr", fc_sclr, 0);
      chk_applied("wait_midframe");
    end
    fc_new_line = 1'b0; fc_v_count = 13'(thr);
    step();
    chk("wait_no_newline_sclr", fc_sclr, 0);
    if (gap > 0) begin
      run = 1'b0; fc_new_line = 1'b1; fc_v_count = 13'(thr);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("frozen_enable", fc_enable, 0);
        chk("frozen_sclr", fc_sclr, 0);
      end
      run = 1'b1;
      #1;
      chk("resume_enable", fc_enable, 1);
    end
    fc_new_line = 1'b1; fc_v_count = 13'(thr);
    snap(id);
    step();
    fc_new_line = 1'b0;
    settle_seq("eof_load");
  endtask

  initial begin
    #2;
    chk_reset("reset");
    step(); step();
    rst_n = 1'b1; run = 1'b1;

    wr(1, 858, 525, 0, 0);
    req_err_seq(2);
    req_idle(1);
    chk("mode1_v_total", fc_v_total, 525);

    wr(0, 1650, 750, $urandom_range(0, 1649), $urandom_range(0, 749));
    req_run(0, $urandom_range(1, 5), 0);
    chk("mode0_h_total", fc_h_total, 1650);

    req_run(1, 2, 100);

    wr(1, 858, 625, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rewrite_hold_v_total", fc_v_total, 525);
    end
    req_run(1, 3, 0);
    chk("rewrite_loaded_v_total", fc_v_total, 625);

    // Reset in the middle of the settle hold
    mode_req_valid = 1'b1; mode_req_id = 2'd0;
    step();
    mode_req_valid = 1'b0; fc_new_line = 1'b1; fc_v_count = 13'(a_vt - 1);
    step();
    fc_new_line = 1'b0;
    chk("pre_reset_sclr", fc_sclr, 1);
    step(); step(); step();
    chk("pre_reset_enable", fc_enable, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_ok[i] = 1'b0;
    a_ht = 0; a_vt = 0; a_hr = 0; a_vr = 0; a_id = 0;
    #1;
    chk_reset("async_reset");
    step();
    rst_n = 1'b1;
    req_err_seq(1);

    // Write to the entry being loaded in the same cycle: old value loads, new one is kept
    wr(3, 1000, 400, 10, 20);
    cfg_wr = 1'b1; cfg_addr = 2'd3;
    cfg_h_total = 14'd1100; cfg_v_total = 13'd450; cfg_h_reset = 14'd11; cfg_v_reset = 13'd21;
    req_idle(3);
    chk("same_cycle_wr_old", fc_v_total, 400);
    m_ht[3] = 1100; m_vt[3] = 450; m_hr[3] = 11; m_vr[3] = 21;
    req_run(3, 1, 0);
    chk("same_cycle_wr_new", fc_v_total, 450);

    for (int it = 0; it < 14; it++) begin
      int id;
      id = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0)
        wr(id, $urandom_range(1, 16383), $urandom_range(2, 8191),
           $urandom_range(0, 16383), $urandom_range(0, 8191));
      else if (!m_ok[id])
        req_err_seq(id);
      else
        req_run(id, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
